// File: rtl/niosii_multi_timer_pkg.sv
// niosii_multi_timer_pkg
// Shared definitions for the multi-channel interval timer: register offsets
// inside a channel's 8-word window, CONTROL/STATUS bit positions, and the
// bundle of per-channel write strobes that the top hands to each channel.
package niosii_multi_timer_pkg;

  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_SNAP     = 3'd3;
  localparam logic [2:0] REG_PRESCALE = 3'd4;

  // STATUS bits
  localparam int BIT_TO  = 0;
  localparam int BIT_RUN = 1;

  // CONTROL bits; START and STOP are strobes and are never stored
  localparam int BIT_ITO   = 0;
  localparam int BIT_CONT  = 1;
  localparam int BIT_START = 2;
  localparam int BIT_STOP  = 3;

  typedef struct packed {
    logic status;
    logic control;
    logic period;
    logic snap;
    logic prescale;
  } chan_wr_t;

endpackage

// File: rtl/niosii_timer_channel.sv
// niosii_timer_channel
// One timer channel: prescaler, down-counter with reload, RUN/TO flags,
// snapshot register and the CONTROL/PERIOD/PRESCALE registers.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   wr             one-hot write strobes for this channel's registers
//   wdata          bus write data
//   *_rd           zero-extended register values for the read mux
//   irq            level interrupt, TO gated by ITO
module niosii_timer_channel
  import niosii_multi_timer_pkg::*;
#(
  parameter int COUNTER_WIDTH  = 32,
  parameter int PRESCALE_WIDTH = 16,
  parameter int DEFAULT_PERIOD = 49
) (
  input  logic        clk,
  input  logic        reset,
  input  chan_wr_t    wr,
  input  logic [31:0] wdata,
  output logic [31:0] status_rd,
  output logic [31:0] control_rd,
  output logic [31:0] period_rd,
  output logic [31:0] snap_rd,
  output logic [31:0] prescale_rd,
  output logic        irq
);

  logic [COUNTER_WIDTH-1:0]  counter_q, counter_d;
  logic [COUNTER_WIDTH-1:0]  period_q, period_d;
  logic [COUNTER_WIDTH-1:0]  snap_q, snap_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] pcount_q, pcount_d;
  logic run_q, run_d;
  logic to_q, to_d;
  logic ito_q, ito_d;
  logic cont_q, cont_d;

  logic tick;
  logic timeout;

  always_comb begin
    tick    = run_q && (pcount_q == prescale_q);
    timeout = tick && (counter_q == '0);

    counter_d  = counter_q;
    period_d   = period_q;
    snap_d     = snap_q;
    prescale_d = prescale_q;
    pcount_d   = pcount_q;
    run_d      = run_q;
    to_d       = to_q;
    ito_d      = ito_q;
    cont_d     = cont_q;

    if (run_q) begin
      pcount_d = tick ? '0 : pcount_q + PRESCALE_WIDTH'(1);
    end

    // Reload on expiry always goes to PERIOD, so the counter never wraps to all-ones
    if (tick) begin
      counter_d = timeout ? period_q : counter_q - COUNTER_WIDTH'(1);
    end

    if (timeout && !cont_q) begin
      run_d = 1'b0;
    end

    // START resumes from the current counter/prescale state; STOP has priority
    if (wr.control) begin
      ito_d  = wdata[BIT_ITO];
      cont_d = wdata[BIT_CONT];
      if (wdata[BIT_START]) run_d = 1'b1;
      if (wdata[BIT_STOP])  run_d = 1'b0;
    end

    if (wr.prescale) begin
      prescale_d = wdata[PRESCALE_WIDTH-1:0];
      pcount_d   = '0;
    end

    // A new period stops the channel and preloads the counter with it
    if (wr.period) begin
      period_d  = wdata[COUNTER_WIDTH-1:0];
      counter_d = wdata[COUNTER_WIDTH-1:0];
      pcount_d  = '0;
      run_d     = 1'b0;
    end

    if (wr.snap) begin
      snap_d = counter_q;
    end

    // A timeout in the same cycle as a STATUS write must not be lost
    if (wr.status) to_d = 1'b0;
    if (timeout)   to_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q  <= COUNTER_WIDTH'(DEFAULT_PERIOD);
      period_q   <= COUNTER_WIDTH'(DEFAULT_PERIOD);
      snap_q     <= '0;
      prescale_q <= '0;
      pcount_q   <= '0;
      run_q      <= 1'b0;
      to_q       <= 1'b0;
      ito_q      <= 1'b0;
      cont_q     <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      period_q   <= period_d;
      snap_q     <= snap_d;
      prescale_q <= prescale_d;
      pcount_q   <= pcount_d;
      run_q      <= run_d;
      to_q       <= to_d;
      ito_q      <= ito_d;
      cont_q     <= cont_d;
    end
  end

  always_comb begin
    status_rd           = '0;
    status_rd[BIT_TO]   = to_q;
    status_rd[BIT_RUN]  = run_q;
    control_rd          = '0;
    control_rd[BIT_ITO] = ito_q;
    control_rd[BIT_CONT] = cont_q;
    period_rd           = 32'(period_q);
    snap_rd             = 32'(snap_q);
    prescale_rd         = 32'(prescale_q);
  end

  assign irq = to_q & ito_q;

endmodule

// File: rtl/niosii_multi_timer.sv
// niosii_multi_timer
// NUM_CHANNELS independent interval timers behind one Avalon-MM slave.
// Address = {channel index, register offset[2:0]}.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   address        {channel, offset}
//   chipselect     slave select
//   write_n        active-low write
//   writedata      write data
//   readdata       registered read data, one cycle after the address
//   irq            per-channel level interrupts
//   irq_any        OR of all channel interrupts
module niosii_multi_timer
  import niosii_multi_timer_pkg::*;
#(
  parameter  int NUM_CHANNELS   = 4,
  parameter  int COUNTER_WIDTH  = 32,
  parameter  int PRESCALE_WIDTH = 16,
  parameter  int DEFAULT_PERIOD = 49,
  localparam int ADDR_WIDTH     = $clog2(NUM_CHANNELS) + 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [NUM_CHANNELS-1:0] irq,
  output logic                    irq_any
);

  logic [28:0] chan_idx;
  logic [2:0]  reg_off;
  logic        wr_en;

  // Shift rather than slice so a single-channel build (no index bits) still elaborates
  assign chan_idx = 29'(address >> 3);
  assign reg_off  = address[2:0];
  assign wr_en    = chipselect & ~write_n;

  logic [31:0] status_rd   [NUM_CHANNELS];
  logic [31:0] control_rd  [NUM_CHANNELS];
  logic [31:0] period_rd   [NUM_CHANNELS];
  logic [31:0] snap_rd     [NUM_CHANNELS];
  logic [31:0] prescale_rd [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] chan_irq;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    logic     hit;
    chan_wr_t wr;

    assign hit         = wr_en && (chan_idx == 29'(i));
    assign wr.status   = hit && (reg_off == REG_STATUS);
    assign wr.control  = hit && (reg_off == REG_CONTROL);
    assign wr.period   = hit && (reg_off == REG_PERIOD);
    assign wr.snap     = hit && (reg_off == REG_SNAP);
    assign wr.prescale = hit && (reg_off == REG_PRESCALE);

    niosii_timer_channel #(
      .COUNTER_WIDTH  (COUNTER_WIDTH),
      .PRESCALE_WIDTH (PRESCALE_WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .wr          (wr),
      .wdata       (writedata),
      .status_rd   (status_rd[i]),
      .control_rd  (control_rd[i]),
      .period_rd   (period_rd[i]),
      .snap_rd     (snap_rd[i]),
      .prescale_rd (prescale_rd[i]),
      .irq         (chan_irq[i])
    );
  end

  // Read mux runs every cycle regardless of chipselect; unmapped offsets
  // and out-of-range channels fall through to zero
  logic [31:0] readdata_d, readdata_q;

  always_comb begin
    readdata_d = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (chan_idx == 29'(c)) begin
        case (reg_off)
          REG_STATUS:   readdata_d = status_rd[c];
          REG_CONTROL:  readdata_d = control_rd[c];
          REG_PERIOD:   readdata_d = period_rd[c];
          REG_SNAP:     readdata_d = snap_rd[c];
          REG_PRESCALE: readdata_d = prescale_rd[c];
          default:      readdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = chan_irq;
  assign irq_any  = |chan_irq;

endmodule

// File: tb/tb_niosii_multi_timer.sv
// tb_niosii_multi_timer
// Directed bench for a 3-channel timer build: reset state, auto-reload and
// one-shot timing, snapshot capture, STATUS/timeout collision, START|STOP,
// out-of-range channel accesses and reset in the middle of a count.
module tb_niosii_multi_timer;

  localparam int NCH = 3;
  localparam int AW  = $clog2(NCH) + 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [AW-1:0]  address = '0;
  logic           chipselect = 1'b0;
  logic           write_n = 1'b1;
  logic [31:0]    writedata = '0;
  logic [31:0]    readdata;
  logic [NCH-1:0] irq;
  logic           irq_any;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  niosii_multi_timer #(
    .NUM_CHANNELS   (NCH),
    .COUNTER_WIDTH  (32),
    .PRESCALE_WIDTH (16),
    .DEFAULT_PERIOD (49)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_any    (irq_any)
  );

  // All bus tasks are entered at a falling edge; the access happens on the
  // next rising edge and the task returns at the following falling edge.
  task automatic bus_write(input int ch, input int off, input logic [31:0] data);
    address    = AW'(ch * 8 + off);
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input int ch, input int off, output logic [31:0] data);
    address    = AW'(ch * 8 + off);
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    data       = readdata;
    chipselect = 1'b0;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_read(input int ch, input int off, input logic [31:0] exp, input string tag);
    logic [31:0] data;
    bus_read(ch, off, data);
    check_output(tag, data, exp);
  endtask

  // Every mapped channel shows reset values; channel 3 and offsets 5-7 read 0
  task automatic check_reset_state(input string phase);
    for (int ch = 0; ch <= NCH; ch++) begin
      for (int off = 0; off < 8; off++) begin
        check_read(ch, off, (ch < NCH && off == 2) ? 32'd49 : 32'd0,
                   $sformatf("%s ch%0d off%0d", phase, ch, off));
      end
    end
    check_output({phase, " irq"}, 32'(irq), 32'd0);
    check_output({phase, " irq_any"}, 32'(irq_any), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before test completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check_reset_state("reset");

    // Channel 0: PERIOD=4, PRESCALE=0, ITO|CONT|START -> timeout every 5 clocks
    bus_write(0, 2, 32'd4);
    bus_write(0, 1, 32'h7);
    repeat (4) @(negedge clk);
    check_output("ch0 irq before first timeout", 32'(irq[0]), 32'd0);
    @(negedge clk);
    check_output("ch0 irq at first timeout", 32'(irq[0]), 32'd1);
    check_output("irq_any with ch0", 32'(irq_any), 32'd1);
    repeat (4) @(negedge clk);
    check_output("ch0 irq sticky", 32'(irq[0]), 32'd1);
    // This STATUS write lands on the second timeout edge: TO must stay set
    bus_write(0, 0, 32'd0);
    check_output("ch0 status write vs timeout", 32'(irq[0]), 32'd1);
    bus_write(0, 0, 32'd0);
    check_output("ch0 irq cleared", 32'(irq[0]), 32'd0);
    repeat (3) @(negedge clk);
    check_output("ch0 irq before third timeout", 32'(irq[0]), 32'd0);
    @(negedge clk);
    check_output("ch0 irq at third timeout", 32'(irq[0]), 32'd1);
    check_read(0, 0, 32'd3, "ch0 status running");
    // START|STOP together: STOP wins, counter holds at 2
    bus_write(0, 1, 32'hF);
    check_read(0, 0, 32'd1, "ch0 status after start_stop");
    check_read(0, 1, 32'd3, "ch0 control strobes read 0");
    bus_write(0, 0, 32'd0);
    repeat (10) @(negedge clk);
    check_read(0, 0, 32'd0, "ch0 stays stopped");
    bus_write(0, 3, 32'd0);
    check_read(0, 3, 32'd2, "ch0 held counter");

    // Channel 1: one-shot PERIOD=2, PRESCALE=3 -> timeout 12 clocks after start
    bus_write(1, 2, 32'd2);
    bus_write(1, 4, 32'd3);
    bus_write(1, 1, 32'h4);
    repeat (10) @(negedge clk);
    check_read(1, 0, 32'd2, "ch1 running clock 11");
    check_read(1, 0, 32'd2, "ch1 running clock 12");
    check_read(1, 0, 32'd1, "ch1 one-shot done");
    check_output("ch1 irq masked", 32'(irq), 32'd0);
    check_output("irq_any idle", 32'(irq_any), 32'd0);
    bus_write(1, 3, 32'd0);
    check_read(1, 3, 32'd2, "ch1 counter reloaded");
    check_read(1, 4, 32'd3, "ch1 prescale readback");
    repeat (20) @(negedge clk);
    check_read(1, 0, 32'd1, "ch1 no restart");

    // Channel 2: PERIOD=100 running, snapshot taken on the 10th clock
    bus_write(2, 2, 32'd100);
    bus_write(2, 1, 32'h4);
    repeat (9) @(negedge clk);
    bus_write(2, 3, 32'd0);
    check_read(2, 3, 32'd91, "ch2 snapshot");
    bus_write(2, 2, 32'd20);
    check_read(2, 0, 32'd0, "ch2 stopped by period write");
    repeat (5) @(negedge clk);
    bus_write(2, 3, 32'd0);
    check_read(2, 3, 32'd20, "ch2 counter equals new period");
    check_read(2, 2, 32'd20, "ch2 period readback");

    // Channel index 3 does not exist: reads 0, writes have no effect
    bus_write(3, 2, 32'd7);
    bus_write(3, 1, 32'h7);
    bus_write(3, 4, 32'd5);
    for (int off = 0; off < 8; off++) begin
      check_read(3, off, 32'd0, $sformatf("ch3 off%0d", off));
    end
    check_read(0, 2, 32'd4, "ch0 period intact");
    check_read(0, 1, 32'd3, "ch0 control intact");
    check_read(1, 2, 32'd2, "ch1 period intact");
    check_read(1, 4, 32'd3, "ch1 prescale intact");
    check_read(2, 2, 32'd20, "ch2 period intact");
    check_read(2, 4, 32'd0, "ch2 prescale intact");
    check_output("irq after ch3 writes", 32'(irq), 32'd0);

    // Restart channel 0 (counter 2) and reset it once TO is up
    bus_write(0, 1, 32'h7);
    repeat (5) @(negedge clk);
    check_output("ch0 irq before reset", 32'(irq), 32'd1);
    address = AW'(0);
    reset   = 1'b1;
    @(negedge clk);
    check_output("readdata in reset", readdata, 32'd0);
    check_output("irq in reset", 32'(irq), 32'd0);
    check_output("irq_any in reset", 32'(irq_any), 32'd0);
    reset = 1'b0;
    check_reset_state("after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
